prime_bench_ctrl: RTL and testbench

//  Parametrised benchmark controller for the primogen prime generator on board tops.

---
 rtl/prime_bench_pkg.sv | 19 +
 rtl/prime_bench_progress.sv | 19 +
 rtl/prime_bench_ctrl.sv | 116 +++++++++++
 tb/tb_prime_bench_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/prime_bench_pkg.sv
// Shared types and helpers for the primogen benchmark controller.
package prime_bench_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StDone,
    StFail
  } state_e;

  // Lower bound for progress LED i: i * 2^w / nleds, widened so w up to 32 cannot overflow.
  function automatic logic [63:0] progress_thresh(int unsigned w, int unsigned nleds,
                                                  int unsigned i);
    return (64'(i) << w) / 64'(nleds);
  endfunction

endpackage

// File: rtl/prime_bench_progress.sv
// Thermometer decoder: lights LED i once the value reaches i/NLEDS of the W-bit range.
module prime_bench_progress
  import prime_bench_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned NLEDS = 4
) (
  input  logic [W-1:0]     last_prime_i,
  output logic [NLEDS-1:0] progress_o
);

  assign progress_o[0] = |last_prime_i;

  for (genvar i = 1; i < NLEDS; i++) begin : g_led
    localparam logic [63:0] Thresh = progress_thresh(W, NLEDS, i);
    assign progress_o[i] = 64'(last_prime_i) >= Thresh;
  end

endmodule

// File: rtl/prime_bench_ctrl.sv
// Benchmark sequencer for primogen: issues requests, captures and counts primes, drives LEDs.
// Optional cycle counter enabled by defining PRIME_BENCH_CYCLES_EN.
module prime_bench_ctrl
  import prime_bench_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned NLEDS   = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned STOP_AT = 65521,
  parameter int unsigned TW      = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clear_i,
  output logic             pg_go_o,
  input  logic             pg_ready_i,
  input  logic             pg_error_i,
  input  logic [W-1:0]     pg_res_i,
  output logic [W-1:0]     last_prime_o,
  output logic [CW-1:0]    prime_count_o,
  output logic [NLEDS-1:0] progress_o,
  output logic             done_led_o,
  output logic             err_led_o,
  output logic [TW-1:0]    cycle_count_o
);

  localparam logic [W-1:0] StopAt = W'(STOP_AT);

  state_e        state_q, state_d;
  logic          pg_go_q;
  logic [W-1:0]  last_prime_q, last_prime_d;
  logic [CW-1:0] prime_count_q, prime_count_d;

  always_comb begin
    state_d       = state_q;
    last_prime_d  = last_prime_q;
    prime_count_d = prime_count_q;
    if (clear_i) begin
      state_d       = StIdle;
      last_prime_d  = '0;
      prime_count_d = '0;
    end else begin
      unique case (state_q)
        StIdle:  if (run_i && pg_ready_i) state_d = StIssue;
        StIssue: state_d = StGuard;
        // primogen has not yet seen go, so its ready is stale here.
        StGuard: state_d = StWait;
        StWait: begin
          if (pg_error_i) begin
            state_d = StFail;
          end else if (pg_ready_i) begin
            last_prime_d = pg_res_i;
            if (!(&prime_count_q)) prime_count_d = prime_count_q + CW'(1);
            if (pg_res_i >= StopAt) state_d = StDone;
            else if (run_i)         state_d = StIssue;
            else                    state_d = StIdle;
          end
        end
        StDone, StFail: state_d = state_q;
        default:        state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      pg_go_q       <= 1'b0;
      last_prime_q  <= '0;
      prime_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pg_go_q       <= (state_d == StIssue);
      last_prime_q  <= last_prime_d;
      prime_count_q <= prime_count_d;
    end
  end

  assign pg_go_o       = pg_go_q;
  assign last_prime_o  = last_prime_q;
  assign prime_count_o = prime_count_q;
  assign done_led_o    = (state_q == StDone);
  assign err_led_o     = (state_q == StFail);

  prime_bench_progress #(
    .W     (W),
    .NLEDS (NLEDS)
  ) u_progress (
    .last_prime_i (last_prime_q),
    .progress_o   (progress_o)
  );

`ifdef PRIME_BENCH_CYCLES_EN
  logic [TW-1:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (clear_i) begin
      cycle_count_d = '0;
    end else if ((state_q inside {StIssue, StGuard, StWait}) && !(&cycle_count_q)) begin
      cycle_count_d = cycle_count_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_count_q <= '0;
    else         cycle_count_q <= cycle_count_d;
  end

  assign cycle_count_o = cycle_count_q;
`else
  assign cycle_count_o = '0;
`endif

endmodule

// File: tb/tb_prime_bench_ctrl.sv
// Directed bench: two controllers (STOP_AT 65521 and 7), each fed by a 3-cycle primogen stub.
module tb_prime_bench_ctrl;

`ifdef PRIME_BENCH_CYCLES_EN
  localparam bit CycEn = 1'b1;
`else
  localparam bit CycEn = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni, run, clear, stub_clr;
  logic [15:0] script_res [4];
  logic [3:0]  script_err;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic        pg_go, ready, err;
    logic [15:0] res, last_prime, prime_count;
    logic [3:0]  progress;
    logic        done, errl;
    logic [31:0] cyc;
    logic [1:0]  idx;
    int          lat, go_cnt;
    logic        go_prev;
    int          viol = 0;

    prime_bench_ctrl #(
      .W       (16),
      .NLEDS   (4),
      .CW      (16),
      .STOP_AT (k == 0 ? 65521 : 7),
      .TW      (32)
    ) u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .run_i         (run),
      .clear_i       (clear),
      .pg_go_o       (pg_go),
      .pg_ready_i    (ready),
      .pg_error_i    (err),
      .pg_res_i      (res),
      .last_prime_o  (last_prime),
      .prime_count_o (prime_count),
      .progress_o    (progress),
      .done_led_o    (done),
      .err_led_o     (errl),
      .cycle_count_o (cyc)
    );

    // Stub primogen: go seen at edge E, result/error presented at edge E+2.
    always @(posedge clk_i) begin
      if (stub_clr) begin
        ready <= 1'b1; err <= 1'b0; res <= '0;
        lat <= 0; idx <= '0; go_cnt <= 0; go_prev <= 1'b0;
      end else begin
        go_prev <= pg_go;
        if (pg_go && go_prev) viol <= viol + 1;
        if (pg_go) begin
          go_cnt <= go_cnt + 1; ready <= 1'b0; err <= 1'b0; lat <= 2;
        end else if (lat == 1) begin
          ready <= 1'b1; res <= script_res[idx]; err <= script_err[idx];
          idx <= idx + 2'd1; lat <= 0;
        end else if (lat > 1) begin
          lat <= lat - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic restart(input logic [15:0] r0, r1, r2, r3, input logic [3:0] e);
    script_res[0] = r0; script_res[1] = r1; script_res[2] = r2; script_res[3] = r3;
    script_err = e;
    run = 1'b0; clear = 1'b1; stub_clr = 1'b1;
    @(negedge clk_i);
    clear = 1'b0; stub_clr = 1'b0;
  endtask

  task automatic wait_count0(input int k);
    for (int i = 0; i < 100 && g_dut[0].prime_count != 16'(k); i++) @(negedge clk_i);
  endtask

  // Drops run while dut0 is issuing its n-th request (n counted from 1).
  task automatic stop_at_go0(input int n);
    for (int i = 0; i < 100 && !(g_dut[0].pg_go && g_dut[0].go_cnt == n - 1); i++)
      @(negedge clk_i);
    run = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b1; run = 1'b0; clear = 1'b0; stub_clr = 1'b1;
    script_res[0] = '0; script_res[1] = '0; script_res[2] = '0; script_res[3] = '0;
    script_err = '0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_last", 64'(g_dut[0].last_prime), 0);
    check("rst_count", 64'(g_dut[0].prime_count), 0);
    check("rst_flags", 64'({g_dut[0].pg_go, g_dut[0].done, g_dut[0].errl, g_dut[0].progress}), 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Primes 2,3,5,7 with run held; run dropped during the 4th request.
    restart(16'd2, 16'd3, 16'd5, 16'd7, 4'b0000);
    run = 1'b1;
    stop_at_go0(4);
    wait_count0(4);
    repeat (3) @(negedge clk_i);
    check("A_count", 64'(g_dut[0].prime_count), 4);
    check("A_last", 64'(g_dut[0].last_prime), 7);
    check("A_go_pulses", 64'(g_dut[0].go_cnt), 4);
    check("A_progress", 64'(g_dut[0].progress), 64'b0001);
    check("A_done0", 64'(g_dut[0].done), 0);
    check("A_cycles", 64'(g_dut[0].cyc), CycEn ? 16 : 0);
    check("S7_done", 64'(g_dut[1].done), 1);
    check("S7_last", 64'(g_dut[1].last_prime), 7);
    check("S7_cycles", 64'(g_dut[1].cyc), CycEn ? 16 : 0);
    run = 1'b1;
    repeat (20) @(negedge clk_i);
    check("S7_no_go", 64'(g_dut[1].go_cnt), 4);
    check("S7_sticky", 64'({g_dut[1].done, g_dut[1].errl}), 64'b10);
    check("S7_cycles_frozen", 64'(g_dut[1].cyc), CycEn ? 16 : 0);

    // Error reported on the 3rd request.
    restart(16'd2, 16'd3, 16'd5, 16'd7, 4'b0100);
    run = 1'b1;
    for (int i = 0; i < 100 && !g_dut[0].errl; i++) @(negedge clk_i);
    check("F_err", 64'(g_dut[0].errl), 1);
    check("F_count", 64'(g_dut[0].prime_count), 2);
    check("F_last", 64'(g_dut[0].last_prime), 3);
    repeat (10) @(negedge clk_i);
    check("F_sticky", 64'({g_dut[0].errl, g_dut[0].done}), 64'b10);
    check("F_no_go", 64'(g_dut[0].go_cnt), 3);
    check("F_err7", 64'(g_dut[1].errl), 1);

    // Clear arrives in the same cycle as ready+error.
    restart(16'd2, 16'd0, 16'd0, 16'd0, 4'b0010);
    run = 1'b1;
    for (int i = 0; i < 100 && !(g_dut[0].ready && g_dut[0].err); i++) @(negedge clk_i);
    check("C_pre_count", 64'(g_dut[0].prime_count), 1);
    clear = 1'b1; run = 1'b0;
    @(negedge clk_i);
    clear = 1'b0;
    check("C_err", 64'(g_dut[0].errl), 0);
    check("C_count", 64'(g_dut[0].prime_count), 0);
    check("C_last", 64'(g_dut[0].last_prime), 0);
    repeat (5) @(negedge clk_i);
    check("C_idle", 64'({g_dut[0].errl, g_dut[0].done, g_dut[0].pg_go}), 0);

    // Progress bar thresholds.
    restart(16'h0001, 16'h4000, 16'hBFFF, 16'hC000, 4'b0000);
    run = 1'b1;
    wait_count0(1);
    check("P_0001", 64'(g_dut[0].progress), 64'b0001);
    wait_count0(2);
    check("P_4000", 64'(g_dut[0].progress), 64'b0011);
    wait_count0(3);
    check("P_BFFF", 64'(g_dut[0].progress), 64'b0111);
    stop_at_go0(4);
    wait_count0(4);
    check("P_C000", 64'(g_dut[0].progress), 64'b1111);
    check("P_last", 64'(g_dut[0].last_prime), 64'hC000);
    repeat (3) @(negedge clk_i);
    check("P_cycles", 64'(g_dut[0].cyc), CycEn ? 16 : 0);
    check("P_done7", 64'(g_dut[1].done), 1);

    // Asynchronous reset while waiting on the 2nd request.
    restart(16'd2, 16'd3, 16'd5, 16'd7, 4'b0000);
    run = 1'b1;
    for (int i = 0; i < 100 && !(g_dut[0].pg_go && g_dut[0].go_cnt == 1); i++)
      @(negedge clk_i);
    @(negedge clk_i); @(negedge clk_i);
    check("R_pre_count", 64'(g_dut[0].prime_count), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("R_last", 64'(g_dut[0].last_prime), 0);
    check("R_count", 64'(g_dut[0].prime_count), 0);
    check("R_progress", 64'(g_dut[0].progress), 0);
    check("R_cycles", 64'(g_dut[0].cyc), 0);
    run = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("R_idle", 64'({g_dut[0].pg_go, g_dut[0].done, g_dut[0].errl}), 0);

    check("go_single_cycle", 64'(g_dut[0].viol + g_dut[1].viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
